// File: rtl/led_pkg.sv
// Shared types for the LED strip path: pixel word, framer states and the
// framer's debug view. The WS2812 serializer imports this package too.
package led_pkg;

  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } framer_state_t;

  // Internal visibility for checkers and bring-up.
  typedef struct packed {
    framer_state_t state;
    logic          too_long;
    logic          ce_level;
    logic          sck_level;
    logic          sck_fall;
  } framer_dbg_t;

endpackage

// File: rtl/spi_pixel_framer_if.sv
// Pixel stream from the framer to the WS2812 serializer.
// Handshake: a word moves on a clk edge where pixel_valid && pixel_ready.
// Once pixel_valid is high, pixel_valid and pixel_data hold until that edge;
// pixel_ready may change at any time and never depends on pixel_valid.
interface spi_pixel_framer_if;
  import led_pkg::*;

  pixel_t pixel_data;
  logic   pixel_valid;
  logic   pixel_ready;

  modport master (output pixel_data, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, input pixel_valid, output pixel_ready);

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a registered copy of
// the synced level so rise/fall can be seen for exactly one clk.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_pixel_framer.sv
// Receives one strip frame over SPI mode 0 (MSB first), buffers one word per
// LED and streams the words to the serializer, then holds the latch gap.
module spi_pixel_framer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 24,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       ce,
  spi_pixel_framer_if.master         pix_if,
  output logic                       latch,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       overrun,
  output framer_dbg_t                o_dbg
);

  localparam int BIT_W = $clog2(PIXEL_W + 1);
  localparam int IDX_W = $clog2(NUM_LEDS + 1);
  localparam int LAT_W = $clog2(LATCH_CYCLES);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIXEL_W - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_LEDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  // Synchronized pins
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_ce_level, w_ce_rise, w_ce_fall;
  logic r_sdi_meta, r_sdi_sync;

  // FSM and datapath state
  framer_state_t      r_state, w_state_next;
  logic [PIXEL_W-2:0] r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [IDX_W-1:0]   r_pix_cnt;
  logic [IDX_W-1:0]   r_out_idx;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_too_long;
  pixel_t             r_buf [NUM_LEDS];
  pixel_t             r_pixel_data;
  logic               r_pixel_valid;

  // Decoded controls
  pixel_t w_shift_next;
  logic   w_shift_en;
  logic   w_buf_we;
  logic   w_xfer;

  sync_edge u_sync_sck (
    .clk     (clk),
    .reset   (reset),
    .i_async (sck),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge u_sync_ce (
    .clk     (clk),
    .reset   (reset),
    .i_async (ce),
    .o_level (w_ce_level),
    .o_rise  (w_ce_rise),
    .o_fall  (w_ce_fall)
  );

  // sdi needs only its level; two flops keep it aligned with synced sck.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sdi_meta <= sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  // Next-state decode and one-cycle status pulses.
  always_comb begin
    w_state_next = r_state;
    latch        = 1'b0;
    frame_done   = 1'b0;
    frame_err    = 1'b0;
    overrun      = 1'b0;
    w_xfer       = r_pixel_valid & pix_if.pixel_ready;
    w_shift_next = {r_shift, r_sdi_sync};
    // An sck rise coinciding with the ce fall belongs to no word.
    w_shift_en   = (r_state == RECV) && w_sck_rise && !w_ce_fall;
    w_buf_we     = w_shift_en && (r_bit_cnt == BIT_LAST) && (r_pix_cnt < IDX_FULL);
    case (r_state)
      IDLE: begin
        if (w_ce_rise) w_state_next = RECV;
      end
      RECV: begin
        if (w_ce_fall) begin
          w_state_next = IDLE;
          if (r_pix_cnt == IDX_FULL && r_bit_cnt == '0 && !r_too_long) begin
            w_state_next = SEND;
          end else if (!(r_pix_cnt == '0 && r_bit_cnt == '0)) begin
            frame_err = 1'b1;
          end
        end
      end
      SEND: begin
        overrun = w_ce_rise;
        if (w_xfer && r_out_idx == IDX_LAST) w_state_next = LATCH;
      end
      LATCH: begin
        latch   = 1'b1;
        overrun = w_ce_rise;
        if (r_lat_cnt == LAT_LAST) begin
          frame_done   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Counters, shift register and the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_pix_cnt     <= '0;
      r_out_idx     <= '0;
      r_lat_cnt     <= '0;
      r_too_long    <= 1'b0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit_cnt  <= '0;
          r_pix_cnt  <= '0;
          r_out_idx  <= '0;
          r_lat_cnt  <= '0;
          r_too_long <= 1'b0;
        end
        RECV: begin
          if (w_shift_en) begin
            r_shift <= w_shift_next[PIXEL_W-2:0];
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              if (w_buf_we) r_pix_cnt  <= r_pix_cnt + 1'b1;
              else          r_too_long <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        SEND: begin
          // First SEND cycle loads word 0; afterwards each transfer loads the next.
          if (!r_pixel_valid) begin
            r_pixel_valid <= 1'b1;
            r_pixel_data  <= r_buf[r_out_idx];
          end else if (pix_if.pixel_ready) begin
            if (r_out_idx == IDX_LAST) begin
              r_pixel_valid <= 1'b0;
            end else begin
              r_out_idx    <= r_out_idx + 1'b1;
              r_pixel_data <= r_buf[r_out_idx + 1'b1];
            end
          end
        end
        LATCH: begin
          r_lat_cnt <= (r_lat_cnt == LAT_LAST) ? '0 : r_lat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame buffer: plain registers, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_pix_cnt] <= w_shift_next;
  end

  assign pix_if.pixel_valid = r_pixel_valid;
  assign pix_if.pixel_data  = r_pixel_data;

  // Debug view of the FSM and synced pins.
  always_comb begin
    o_dbg.state     = r_state;
    o_dbg.too_long  = r_too_long;
    o_dbg.ce_level  = w_ce_level;
    o_dbg.sck_level = w_sck_level;
    o_dbg.sck_fall  = w_sck_fall;
  end

endmodule

// File: tb/tb_spi_pixel_framer.sv
// Directed bench for spi_pixel_framer: SPI frames in, pixel stream,
// latch gap and status pulses out.
module tb_spi_pixel_framer;
  import led_pkg::*;

  localparam int NLED = 24;
  localparam int NLAT = 6000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        sdi;
  logic        ce;
  logic        latch;
  logic        frame_done;
  logic        frame_err;
  logic        overrun;
  framer_dbg_t dbg;

  int vectors     = 0;
  int miscompares = 0;
  int ncyc        = 0;

  spi_pixel_framer_if pix_if ();

  spi_pixel_framer #(.NUM_LEDS(NLED), .LATCH_CYCLES(NLAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .ce         (ce),
    .pix_if     (pix_if),
    .latch      (latch),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .o_dbg      (dbg)
  );

  // Clock: 10 ns period
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b);
    sdi = b;
    tick(2);
    sck = 1'b1;
    tick(2);
    sck = 1'b0;
  endtask

  task automatic spi_words(input int n_words, input int n_extra, input logic [23:0] base);
    logic [23:0] word;
    for (int w = 0; w < n_words; w++) begin
      word = base + 24'(w);
      for (int b = 23; b >= 0; b--) spi_bit(word[b]);
    end
    for (int e = 0; e < n_extra; e++) spi_bit(1'b1);
  endtask

  task automatic send_frame(input int n_words, input int n_extra, input logic [23:0] base);
    ce = 1'b1;
    tick(4);
    spi_words(n_words, n_extra, base);
    tick(4);
    ce = 1'b0;
  endtask

  // SPI traffic during SEND/LATCH: one ce rise, then 30 sck rises.
  task automatic noise_step(input bit noise);
    if (noise) begin
      if (ncyc == 2) ce = 1'b1;
      if (ncyc >= 4 && ncyc < 124) begin
        sck = (((ncyc - 4) % 4) >= 2);
        sdi = 1'(($urandom_range(0, 1)));
      end
      if (ncyc == 130) ce = 1'b0;
    end
    ncyc++;
  endtask

  // Called right after ce falls. mode 0: ready high, 1: random, 2: every 3rd cycle.
  task automatic stream_frame(input int mode, input bit noise, input logic [23:0] base);
    int          idx;
    int          guard;
    int          n_valid;
    int          ov;
    int          lat;
    int          done;
    bit          hold;
    logic [23:0] hold_data;
    idx = 0; guard = 0; n_valid = 0; ov = 0; lat = 0; done = 0; hold = 0;
    hold_data = '0;
    ncyc = 0;
    pix_if.pixel_ready = (mode == 0);
    tick(3);
    chk("valid_before_4clk", pix_if.pixel_valid, 1'b0);
    tick(1);
    chk("valid_at_4clk", pix_if.pixel_valid, 1'b1);
    while (idx < NLED && guard < 2000) begin
      if (hold) chk("hold_stable", {pix_if.pixel_valid, pix_if.pixel_data}, {1'b1, hold_data});
      if (mode == 0)      pix_if.pixel_ready = 1'b1;
      else if (mode == 1) pix_if.pixel_ready = 1'(($urandom_range(0, 1)));
      else                pix_if.pixel_ready = ((guard % 3) == 0);
      ov += int'(overrun);
      if (pix_if.pixel_valid) begin
        n_valid++;
        if (pix_if.pixel_ready) begin
          chk($sformatf("word%0d", idx), pix_if.pixel_data, base + 24'(idx));
          idx++;
          hold = 0;
        end else begin
          hold      = 1;
          hold_data = pix_if.pixel_data;
        end
      end
      noise_step(noise);
      tick(1);
      guard++;
    end
    chk("words_delivered", idx, NLED);
    if (mode == 0) chk("burst_len", guard, NLED);
    if (mode == 0) chk("burst_valid_cycles", n_valid, NLED);
    chk("valid_after_last", pix_if.pixel_valid, 1'b0);
    while (latch && lat < NLAT + 100) begin
      if (frame_done) begin
        done++;
        chk("done_on_last_latch", lat, NLAT - 1);
      end
      ov += int'(overrun);
      noise_step(noise);
      tick(1);
      lat++;
    end
    chk("latch_len", lat, NLAT);
    chk("frame_done_count", done, 1);
    chk("idle_after_done", dbg.state, IDLE);
    chk("overrun_count", ov, noise ? 1 : 0);
    pix_if.pixel_ready = 1'b0;
    sck = 1'b0;
    ce  = 1'b0;
  endtask

  // Watch n cycles after a rejected or empty frame.
  task automatic expect_reject(input string tag, input int n_err);
    int errs;
    int vals;
    errs = 0; vals = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      errs += int'(frame_err);
      vals += int'(pix_if.pixel_valid);
    end
    chk({tag, "_frame_err"}, errs, n_err);
    chk({tag, "_no_valid"}, vals, 0);
    chk({tag, "_idle"}, dbg.state, IDLE);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; ce = 1'b0;
    pix_if.pixel_ready = 1'b0;

    // Step 1: reset held 3 cycles
    tick(3);
    chk("reset_outputs",
        {pix_if.pixel_valid, pix_if.pixel_data, latch, frame_done, frame_err, overrun}, '0);
    chk("reset_state", dbg.state, IDLE);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      pulses += int'(pix_if.pixel_valid | latch | frame_done | frame_err | overrun);
    end
    chk("quiet_after_reset", pulses, 0);

    // Step 2: full frame, ready held high
    send_frame(NLED, 0, 24'h010203);
    stream_frame(0, 1'b0, 24'h010203);

    // Step 3: same frame, random ready
    send_frame(NLED, 0, 24'h010203);
    stream_frame(1, 1'b0, 24'h010203);

    // Step 4: short, long and empty frames
    send_frame(NLED - 1, 5, 24'h300000);
    expect_reject("short", 1);
    send_frame(NLED + 1, 0, 24'h400000);
    expect_reject("long", 1);
    send_frame(0, 0, 24'h000000);
    expect_reject("empty", 0);

    // Step 5: ce rise plus sck traffic during SEND, then a clean frame
    send_frame(NLED, 0, 24'hC0FFEE);
    stream_frame(2, 1'b1, 24'hC0FFEE);
    tick(10);
    send_frame(NLED, 0, 24'h800000);
    stream_frame(0, 1'b0, 24'h800000);

    // Step 6: reset after word 10 of a frame, then a full new frame
    ce = 1'b1;
    tick(4);
    spi_words(10, 0, 24'h5A5A00);
    reset = 1'b1;
    ce    = 1'b0;
    tick(1);
    chk("midframe_reset_outputs",
        {pix_if.pixel_valid, pix_if.pixel_data, latch, frame_done, frame_err, overrun}, '0);
    chk("midframe_reset_state", dbg.state, IDLE);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pulses += int'(frame_err | pix_if.pixel_valid);
    end
    chk("no_err_after_reset", pulses, 0);
    send_frame(NLED, 0, 24'hA50000);
    stream_frame(0, 1'b0, 24'hA50000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_pixel_framer.md
# spi_pixel_framer

Receives a full strip frame from the microcontroller over SPI (mode 0, MSB first), buffers one 24-bit GRB word per LED, and streams the words one at a time over a valid/ready handshake to the WS2812 serializer. The latch gap follows the last pixel. Sits directly upstream of the LED bit-timing unit, in the PLL `fclk` domain, which is driven into this block's `clk` port.

## Interface
- `NUM_LEDS`, 24: words per frame.
- `PIXEL_W`, 24: bits per word.
- `LATCH_CYCLES`, 6000: idle clocks after the last pixel (≥50 µs at 100 MHz).
- `clk`  in  1  fabric clock (PLL output).
- `reset`  in  1  synchronous, active-high.
- `sck`  in  1  SPI clock, asynchronous, ≤ clk/4.
- `sdi`  in  1  SPI data, asynchronous.
- `ce`  in  1  SPI chip enable, active-high, asynchronous.
- `pixel_data`  out  PIXEL_W  current word, MSB sent first downstream.
- `pixel_valid`  out  1  `pixel_data` valid.
- `pixel_ready`  in  1  serializer accepts the word.
- `latch`  out  1  high throughout the latch gap.
- `frame_done`  out  1  one-cycle pulse at the end of the latch gap.
- `frame_err`  out  1  one-cycle pulse when a received frame is discarded.
- `overrun`  out  1  one-cycle pulse when `ce` rises while not in IDLE.

## Operation
- Input synchronization:
  - `sck`, `sdi` and `ce` each pass through 2 flops.
  - Rise and fall of synced `sck` and `ce` are detected against a third, registered copy.
- **IDLE**
  - Counters are cleared.
  - Synced `ce` rise goes to RECV.
- **RECV**
  - On each `sck` rise: shift `sdi` into the word shift register; increment `bit_cnt`.
  - On the bit that makes `bit_cnt` = PIXEL_W:
    - if `pix_cnt` < NUM_LEDS, write the word to `buffer[pix_cnt]` and increment `pix_cnt`;
    - otherwise, drop the word and set the sticky `too_long` flag;
    - in both cases, reset `bit_cnt` to 0.
  - On `ce` fall:
    - `pix_cnt` = NUM_LEDS, `bit_cnt` = 0 and `too_long` clear: go to SEND.
    - `pix_cnt` = 0 and `bit_cnt` = 0: go to IDLE silently.
    - Any other case: pulse `frame_err` and go to IDLE.
  - A `sck` rise in the same cycle as `ce` fall is dropped.
- **SEND**
  - `pixel_valid` = 1 and `pixel_data` = `buffer[out_idx]`.
  - On `pixel_valid && pixel_ready`, `out_idx` increments.
  - After the transfer with `out_idx` = NUM_LEDS-1, go to LATCH.
  - `pixel_data` holds stable while valid and not ready.
- **LATCH**
  - `latch` = 1 while `lat_cnt` counts 0..LATCH_CYCLES-1.
  - On the last count, pulse `frame_done` and go to IDLE.
- `ce` rise in SEND or LATCH:
  - pulse `overrun` once per rise;
  - SPI traffic is ignored until IDLE is reached and a new `ce` rise is seen.
  - A `ce` already high when IDLE is entered does not start RECV.
- Buffer contents are not reset. Only the new frame's written words are ever sent.

## Timing
- Reset values, all outputs:
  - `pixel_valid` = 0, `pixel_data` = 0, `latch` = 0, `frame_done` = 0, `frame_err` = 0, `overrun` = 0.
  - State = IDLE; all counters 0; `too_long` clear.
- `sck` pin rise to shift register update: 3 clk.
- `ce` pin fall to first `pixel_valid`: 4 clk (3 to detect, 1 state register).
- Handshake throughput: one word per clk when `pixel_ready` is held high.
- LATCH lasts exactly LATCH_CYCLES clk. IDLE is entered the cycle after `frame_done`.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs at reset values; a partial frame is lost with no `frame_err`.
- Counter widths:
  - `bit_cnt`: $clog2(PIXEL_W+1).
  - `pix_cnt` and `out_idx`: $clog2(NUM_LEDS+1).
  - `lat_cnt`: $clog2(LATCH_CYCLES).
  - No counter wraps in legal operation.

## Structure
- Package `led_pkg`: `PIXEL_W`, `pixel_t` (logic [23:0]), state enum `framer_state_t` {IDLE, RECV, SEND, LATCH}. The serializer imports the same package.
- Sub-module `sync_edge`:
  - 2-flop synchronizer plus registered copy;
  - outputs `level`, `rise`, `fall`;
  - instantiated for `sck` and `ce`; `sdi` uses its `level` only.
- Buffer is a plain register array; no RAM inference required.

## Test plan
- Reset held 3 cycles, then released → all outputs 0, no pulses for 100 clk.
- Full frame of 24 words, word k = 24'h010203 + k, `pixel_ready` held high → 24 consecutive valid cycles starting 4 clk after `ce` fall; data order k = 0..23; then `latch` high for 6000 clk; then one `frame_done` pulse.
- Same frame with `pixel_ready` toggled pseudo-randomly → every word is delivered exactly once, and `pixel_data` never changes while valid and not ready.
- Frame of 23 words plus 5 bits → `frame_err` pulse; no `pixel_valid`. Frame of 25 words → `frame_err`. `ce` pulse with no `sck` → silent return to IDLE.
- `ce` rise during SEND with 30 `sck` edges → one `overrun` pulse, output stream unchanged. The next proper frame after IDLE is received correctly.
- `reset` asserted after word 10 of a RECV frame, then a full 24-word frame → only the new frame is streamed, with correct data.
